// File: rtl/match_alu_pipe.sv
// match_alu_pipe: two-stage pipelined opcode-dispatch ALU with a multiply-accumulate register.
//
// Commands (op, a, b) enter through a valid/ready handshake. Stage 1 registers the command
// and its product. Stage 2 selects the result, updates the accumulator and presents the
// result through a second valid/ready handshake.
//
// Ports:
//   clk        clock, rising edge
//   rst_n      asynchronous active-low reset
//   in_valid   command present
//   in_ready   command accepted when in_valid && in_ready at an edge (combinational)
//   op         opcode
//   a, b       unsigned operands
//   out_valid  result present (registered)
//   out_ready  sink takes the result when out_valid && out_ready at an edge
//   xout       result (registered)
module match_alu_pipe #(
  parameter int unsigned NBITS  = 8,
  parameter int unsigned OPBITS = 8,
  parameter logic [OPBITS-1:0] OP_INC   = OPBITS'(17),
  parameter logic [OPBITS-1:0] OP_ADD   = OPBITS'(21),
  parameter logic [OPBITS-1:0] OP_SUB   = OPBITS'(34),
  parameter logic [OPBITS-1:0] OP_MAC   = OPBITS'(51),
  parameter logic [OPBITS-1:0] OP_RDCLR = OPBITS'(68)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [OPBITS-1:0] op,
  input  logic [NBITS-1:0]  a,
  input  logic [NBITS-1:0]  b,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [NBITS-1:0]  xout
);

  // Whole pipeline advances together; it only holds while a result waits for the sink.
  logic en;

  // Stage 1 registers
  logic              v1_q;
  logic [OPBITS-1:0] op1_q;
  logic [NBITS-1:0]  a1_q;
  logic [NBITS-1:0]  b1_q;
  logic [NBITS-1:0]  p1_q;

  // Stage 2 / architectural state
  logic             out_valid_q;
  logic [NBITS-1:0] xout_q;
  logic [NBITS-1:0] acc_q;
  logic [NBITS-1:0] acc_d;
  logic [NBITS-1:0] res;
  logic [NBITS-1:0] prod_lo;

  assign en       = !out_valid_q || out_ready;
  assign in_ready = en;

  // Every consumer of the product uses it modulo 2^NBITS, so only the low half of the
  // full 2*NBITS product is formed and kept.
  assign prod_lo = a * b;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      v1_q  <= 1'b0;
      op1_q <= '0;
      a1_q  <= '0;
      b1_q  <= '0;
      p1_q  <= '0;
    end else if (en) begin
      v1_q  <= in_valid;
      op1_q <= op;
      a1_q  <= a;
      b1_q  <= b;
      p1_q  <= prod_lo;
    end
  end

  // Result select and accumulator update share this stage, so a MAC always sees the
  // accumulator left by the command directly ahead of it.
  always_comb begin
    res   = p1_q;
    acc_d = acc_q;
    case (op1_q)
      OP_INC:   res = a1_q + NBITS'(1);
      OP_ADD:   res = a1_q + b1_q;
      OP_SUB:   res = a1_q - b1_q;
      OP_MAC: begin
        res   = acc_q + p1_q;
        acc_d = acc_q + p1_q;
      end
      OP_RDCLR: begin
        res   = acc_q;
        acc_d = '0;
      end
      default:  res = p1_q;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid_q <= 1'b0;
      xout_q      <= '0;
      acc_q       <= '0;
    end else if (en) begin
      out_valid_q <= v1_q;
      if (v1_q) begin
        xout_q <= res;
        acc_q  <= acc_d;
      end
    end
  end

  assign out_valid = out_valid_q;
  assign xout      = xout_q;

endmodule

// File: tb/tb_match_alu_pipe.sv
// Self-checking bench for match_alu_pipe (NBITS = 8, OPBITS = 8, default opcodes).
module tb_match_alu_pipe;

  localparam logic [7:0] INC = 8'd17, ADD = 8'd21, SUB = 8'd34, MAC = 8'd51, RDC = 8'd68;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       in_valid = 1'b0;
  logic       in_ready;
  logic [7:0] op = '0;
  logic [7:0] a = '0;
  logic [7:0] b = '0;
  logic       out_valid;
  logic       out_ready = 1'b1;
  logic [7:0] xout;

  match_alu_pipe dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .op        (op),
    .a         (a),
    .b         (b),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .xout      (xout)
  );

  always #5 clk = ~clk;

  int tests = 0;
  int fails = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] want);
    tests++;
    if (act !== want) begin
      fails++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, want, $time);
    end
  endtask

  // Reference model: results computed in command order at acceptance time.
  typedef struct {
    logic [7:0] v;
    int         cyc;
  } exp_t;

  exp_t       q[$];
  logic [7:0] acc_m = '0;
  logic [7:0] seen[$];
  logic [7:0] want_q[$];
  int         cyc = 0;
  int         last_stall = -1;
  int         n_acc = 0;
  bit         prev_stall = 1'b0;
  logic [7:0] prev_x = '0;

  function automatic logic [7:0] model(input logic [7:0] o, input logic [7:0] x,
                                       input logic [7:0] y);
    logic [7:0] r;
    case (o)
      INC: r = x + 8'd1;
      ADD: r = x + y;
      SUB: r = x - y;
      MAC: begin
        acc_m = acc_m + 8'(x * y);
        r     = acc_m;
      end
      RDC: begin
        r     = acc_m;
        acc_m = 8'd0;
      end
      default: r = 8'(x * y);
    endcase
    return r;
  endfunction

  always @(negedge rst_n) begin
    q.delete();
    acc_m      = 8'd0;
    prev_stall = 1'b0;
  end

  // Compare process: samples 1 time unit before each rising edge, when inputs are settled.
  initial begin
    exp_t e;
    forever begin
      @(posedge clk);
      #9;
      cyc++;
      if (rst_n) begin
        chk("in_ready_rule", in_ready, !out_valid || out_ready);
        if (prev_stall) begin
          chk("stall_valid_hold", out_valid, 1);
          chk("stall_xout_hold", xout, prev_x);
        end
        if (out_valid && out_ready) begin
          if (q.size() == 0) begin
            chk("spurious_result", 1, 0);
          end else begin
            e = q.pop_front();
            chk("xout_vs_model", xout, e.v);
            if (last_stall < e.cyc) chk("latency", cyc - e.cyc, 2);
            seen.push_back(xout);
          end
        end
        prev_stall = out_valid && !out_ready;
        prev_x     = xout;
        if (prev_stall) last_stall = cyc;
        if (in_valid && in_ready) begin
          e.v   = model(op, a, b);
          e.cyc = cyc;
          q.push_back(e);
          n_acc++;
        end
      end
    end
  end

  // All stimulus tasks are entered and left 1 time unit after a rising edge.
  task automatic send(input logic [7:0] o, input logic [7:0] x, input logic [7:0] y);
    bit ok;
    ok       = 1'b0;
    in_valid = 1'b1;
    op       = o;
    a        = x;
    b        = y;
    for (int i = 0; i < 10 && !ok; i++) begin
      #8;
      ok = in_ready;
      @(posedge clk);
      #1;
    end
    in_valid = 1'b0;
    chk("send_accept", ok, 1);
  endtask

  task automatic drain();
    out_ready = 1'b1;
    for (int i = 0; i < 20 && (q.size() != 0 || out_valid); i++) begin
      @(posedge clk);
      #1;
    end
    chk("drain_empty", q.size(), 0);
    chk("drain_idle", out_valid, 0);
  endtask

  task automatic check_seen(input string name);
    chk({name, "_count"}, seen.size(), want_q.size());
    for (int i = 0; i < want_q.size() && i < seen.size(); i++) chk(name, seen[i], want_q[i]);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout, expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    // Reset values
    #2;
    chk("rst_in_ready", in_ready, 1);
    chk("rst_out_valid", out_valid, 0);
    chk("rst_xout", xout, 0);
    @(posedge clk);
    #3 rst_n = 1'b1;
    @(posedge clk);
    #1;

    // Basic ops
    seen.delete();
    send(INC, 8'd5, 8'd0);
    send(ADD, 8'd200, 8'd100);
    send(SUB, 8'd3, 8'd5);
    send(8'd99, 8'd20, 8'd20);
    drain();
    want_q = '{8'd6, 8'd44, 8'd254, 8'd144};
    check_seen("basic");

    // MAC chain, back-to-back
    seen.delete();
    send(RDC, 8'd0, 8'd0);
    send(MAC, 8'd3, 8'd4);
    send(MAC, 8'd10, 8'd10);
    send(RDC, 8'd7, 8'd9);
    send(RDC, 8'd1, 8'd1);
    drain();
    want_q = '{8'd0, 8'd12, 8'd112, 8'd112, 8'd0};
    check_seen("mac_chain");

    // MAC wrap: 250 + 10 = 260 mod 256
    seen.delete();
    send(RDC, 8'd0, 8'd0);
    send(MAC, 8'd25, 8'd10);
    send(MAC, 8'd2, 8'd5);
    drain();
    want_q = '{8'd0, 8'd250, 8'd4};
    check_seen("mac_wrap");

    // Backpressure: only two commands fit while the sink stalls
    send(RDC, 8'd0, 8'd0);
    drain();
    seen.delete();
    begin
      int base;
      base      = n_acc;
      out_ready = 1'b0;
      send(MAC, 8'd2, 8'd3);
      send(MAC, 8'd4, 8'd5);
      in_valid = 1'b1;
      op       = MAC;
      a        = 8'd1;
      b        = 8'd1;
      repeat (4) @(posedge clk);
      #1;
      chk("bp_accepted", n_acc - base, 2);
      chk("bp_in_ready", in_ready, 0);
      chk("bp_out_valid", out_valid, 1);
      chk("bp_first_held", xout, 8'd6);
      in_valid  = 1'b0;
      out_ready = 1'b1;
      send(MAC, 8'd1, 8'd1);
      send(RDC, 8'd0, 8'd0);
      drain();
    end
    want_q = '{8'd6, 8'd26, 8'd27, 8'd27};
    check_seen("backpressure");

    // Reset mid-stall with two MACs in flight
    out_ready = 1'b0;
    send(MAC, 8'd3, 8'd3);
    send(MAC, 8'd2, 8'd2);
    chk("pre_rst_valid", out_valid, 1);
    #3 rst_n = 1'b0;
    #1;
    chk("midrst_out_valid", out_valid, 0);
    chk("midrst_xout", xout, 0);
    chk("midrst_acc", dut.acc_q, 0);
    chk("midrst_in_ready", in_ready, 1);
    #1 rst_n = 1'b1;
    @(posedge clk);
    #1;
    out_ready = 1'b1;
    seen.delete();
    send(RDC, 8'd0, 8'd0);
    drain();
    want_q = '{8'd0};
    check_seen("after_rst");

    // Random traffic against the model
    for (int i = 0; i < 400; i++) begin
      logic [7:0] tbl[6];
      tbl       = '{INC, ADD, SUB, MAC, RDC, 8'($urandom)};
      in_valid  = 1'($urandom_range(0, 1));
      op        = tbl[$urandom_range(0, 5)];
      a         = 8'($urandom);
      b         = 8'($urandom);
      out_ready = ($urandom_range(0, 9) < 7);
      @(posedge clk);
      #1;
    end
    in_valid = 1'b0;
    drain();
    seen.delete();
    send(RDC, 8'd0, 8'd0);
    drain();
    chk("final_acc_read_count", seen.size(), 1);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
